// File: rtl/run_monitor.sv
// End-of-run sequencer: detects the halt word, drains the pipeline, then streams the data RAM out.
// Optional watchdog enabled by defining RUN_MONITOR_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module run_monitor #(
    parameter int          DATA_W       = 32,
    parameter int          ADDR_W       = 9,
    parameter int          DUMP_DEPTH   = 512,
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int          CNT_W        = 32
`ifdef RUN_MONITOR_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [31:0]       instr_id,
    input  logic              instr_valid,
    output logic              cpu_run,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic [CNT_W-1:0]  cycles,
    output logic              halted,
    output logic              done,
    output logic              timed_out
);

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_OUT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DUMP_DEPTH - 1);
    localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cycles_q, cycles_d, cycles_inc;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              cpu_run_q, cpu_run_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              dump_valid_q, dump_valid_d;
    logic              halted_q, halted_d;
    logic              done_q, done_d;

    logic halt_hit;
    logic timeout_hit;
    logic start_drain;
    logic drain_last;
    logic last_word;

    // Counter saturates at all-ones instead of wrapping.
    assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    assign halt_hit    = (state_q == RUN) && instr_valid && (instr_id == HALT_WORD);
    assign start_drain = halt_hit || timeout_hit;
    assign drain_last  = (drain_cnt_q == DRAIN_LAST);
    assign last_word   = (ptr_q == LAST_ADDR);

`ifdef RUN_MONITOR_TIMEOUT_EN
    logic timed_out_q;

    // A halt on the same edge takes priority over the watchdog.
    assign timeout_hit = (state_q == RUN) && !halt_hit && (cycles_inc == CNT_W'(TIMEOUT_CYCLES));
    assign timed_out   = timed_out_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            timed_out_q <= 1'b0;
        end else if (timeout_hit) begin
            timed_out_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: a default assignment first keeps combinational blocks free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (start_drain) state_d = (DRAIN_CYCLES == 0) ? DUMP_RD : DRAIN;
            DRAIN:     if (drain_last) state_d = DUMP_RD;
            DUMP_RD:   state_d = DUMP_WAIT;
            DUMP_WAIT: state_d = DUMP_OUT;
            DUMP_OUT:  if (dump_ready) state_d = last_word ? DONE : DUMP_RD;
            DONE:      state_d = DONE;
            default:   state_d = RUN;
        endcase
    end

    // Output logic: next values for every registered output, keyed off current and next state.
    always_comb begin
        cycles_d     = cycles_q;
        halted_d     = halted_q;
        drain_cnt_d  = drain_cnt_q;
        ptr_d        = ptr_q;
        dump_valid_d = dump_valid_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        case (state_q)
            RUN: begin
                cycles_d = cycles_inc;
                if (halt_hit) halted_d = 1'b1;
                if (start_drain) drain_cnt_d = '0;
            end
            DRAIN: begin
                cycles_d    = cycles_inc;
                drain_cnt_d = drain_cnt_q + 4'd1;
            end
            DUMP_WAIT: begin
                dump_data_d  = mem_rd_data;
                dump_addr_d  = ptr_q;
                dump_valid_d = 1'b1;
            end
            DUMP_OUT: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (!last_word) ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
        cpu_run_d     = (state_d == RUN) || (state_d == DRAIN);
        mem_rd_en_d   = (state_d == DUMP_RD);
        mem_rd_addr_d = (state_d == DUMP_RD) ? ptr_d : mem_rd_addr_q;
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycles_q      <= '0;
            halted_q      <= 1'b0;
            drain_cnt_q   <= '0;
            ptr_q         <= '0;
            cpu_run_q     <= 1'b1;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            dump_valid_q  <= 1'b0;
            dump_addr_q   <= '0;
            dump_data_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            cycles_q      <= cycles_d;
            halted_q      <= halted_d;
            drain_cnt_q   <= drain_cnt_d;
            ptr_q         <= ptr_d;
            cpu_run_q     <= cpu_run_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            dump_valid_q  <= dump_valid_d;
            dump_addr_q   <= dump_addr_d;
            dump_data_q   <= dump_data_d;
            done_q        <= done_d;
        end
    end

    assign cycles      = cycles_q;
    assign halted      = halted_q;
    assign cpu_run     = cpu_run_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign dump_valid  = dump_valid_q;
    assign dump_addr   = dump_addr_q;
    assign dump_data   = dump_data_q;
    assign done        = done_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: halt/drain timing, full and stalled dumps, reset abort, optional watchdog.
module tb_run_monitor;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 9;
    localparam int          DEPTH  = 512;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          BUDGET = 20000;

    logic              CLOCK;
    logic              RESET_N;
    logic [31:0]       instr_id;
    logic              instr_valid;
    logic              cpu_run;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic [31:0]       cycles;
    logic              halted;
    logic              done;
    logic              timed_out;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ram [DEPTH];

    run_monitor #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DUMP_DEPTH(DEPTH),
        .DRAIN_CYCLES(2),
        .HALT_WORD(HALT),
        .CNT_W(32)
`ifdef RUN_MONITOR_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(50)
`endif
    ) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .instr_id(instr_id),
        .instr_valid(instr_valid),
        .cpu_run(cpu_run),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr(dump_addr),
        .dump_data(dump_data),
        .cycles(cycles),
        .halted(halted),
        .done(done),
        .timed_out(timed_out)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Synchronous-read data RAM model, word[i] = i*3.
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i * 3);
        mem_rd_data = '0;
    end
    always @(posedge CLOCK) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic release_reset();
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cpu_run"}, 64'(cpu_run), 64'd1);
        check({tag, "_cycles"}, 64'(cycles), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_timed_out"}, 64'(timed_out), 64'd0);
        check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        check({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'd0);
        check({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
        check({tag, "_dump_addr"}, 64'(dump_addr), 64'd0);
        check({tag, "_dump_data"}, 64'(dump_data), 64'd0);
    endtask

    // Hands words off until n have been accepted; checks order, values and stall stability.
    task automatic run_dump(input string tag, input bit random_ready, input int n, output int got);
        int                idx   = 0;
        int                cyc   = 0;
        int                stall = 0;
        bit                pend  = 0;
        logic [ADDR_W-1:0] h_addr = '0;
        logic [DATA_W-1:0] h_data = '0;
        while (idx < n && cyc < BUDGET) begin
            if (random_ready && dump_valid && !pend && (idx % 40) == 13) stall = 5;
            if (!random_ready) begin
                dump_ready = 1'b1;
            end else if (stall > 0) begin
                dump_ready = 1'b0;
                stall--;
            end else begin
                dump_ready = ($urandom_range(0, 3) != 0);
            end
            if (pend) begin
                check({tag, "_hold_valid"}, 64'(dump_valid), 64'd1);
                check({tag, "_hold_addr"}, 64'(dump_addr), 64'(h_addr));
                check({tag, "_hold_data"}, 64'(dump_data), 64'(h_data));
            end
            if (dump_valid && dump_ready) begin
                check({tag, "_addr"}, 64'(dump_addr), 64'(idx));
                check({tag, "_data"}, 64'(dump_data), 64'(idx * 3));
                idx++;
                pend = 1'b0;
            end else if (dump_valid) begin
                pend   = 1'b1;
                h_addr = dump_addr;
                h_data = dump_data;
            end else begin
                pend = 1'b0;
            end
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        if (cyc >= BUDGET) check({tag, "_budget_expired"}, 64'(idx), 64'(n));
        got = idx;
    endtask

    task automatic check_done(input string tag, input int exp_cycles, input bit exp_halted, input bit exp_to);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_valid_low"}, 64'(dump_valid), 64'd0);
        check({tag, "_rd_en_low"}, 64'(mem_rd_en), 64'd0);
        check({tag, "_cpu_run"}, 64'(cpu_run), 64'd0);
        check({tag, "_cycles"}, 64'(cycles), 64'(exp_cycles));
        check({tag, "_halted"}, 64'(halted), 64'(exp_halted));
        check({tag, "_timed_out"}, 64'(timed_out), 64'(exp_to));
        dump_ready = 1'b1;
        repeat (3) tick();
        dump_ready = 1'b0;
        check({tag, "_done_sticky"}, 64'(done), 64'd1);
        check({tag, "_valid_stays_low"}, 64'(dump_valid), 64'd0);
        check({tag, "_cycles_frozen"}, 64'(cycles), 64'(exp_cycles));
    endtask

    initial begin
        int got;
        RESET_N     = 1'b0;
        instr_id    = NOP;
        instr_valid = 1'b0;
        dump_ready  = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        check_reset("rst0");

        // Halt sampled at edge 10, two drain cycles, ready always high.
        release_reset();
        instr_valid = 1'b1;
        repeat (9) tick();
        check("t1_cycles_e9", 64'(cycles), 64'd9);
        check("t1_halted_e9", 64'(halted), 64'd0);
        instr_id = HALT;
        tick();
        check("t1_halted_e10", 64'(halted), 64'd1);
        check("t1_cycles_e10", 64'(cycles), 64'd10);
        check("t1_cpu_run_e10", 64'(cpu_run), 64'd1);
        tick();
        instr_id = NOP;
        check("t1_cycles_e11", 64'(cycles), 64'd11);
        check("t1_cpu_run_e11", 64'(cpu_run), 64'd1);
        tick();
        check("t1_cycles_e12", 64'(cycles), 64'd12);
        check("t1_cpu_run_e12", 64'(cpu_run), 64'd0);
        check("t1_rd_en_e12", 64'(mem_rd_en), 64'd1);
        check("t1_rd_addr_e12", 64'(mem_rd_addr), 64'd0);
        run_dump("t1", 1'b0, DEPTH, got);
        check("t1_words", 64'(got), 64'(DEPTH));
        check_done("t1", 12, 1'b1, 1'b0);

        // Halt word with instr_valid low is ignored; valid halt at edge 20; random ready with stalls.
        RESET_N = 1'b0;
        #1;
        check_reset("rst1");
        release_reset();
        instr_valid = 1'b1;
        repeat (16) tick();
        instr_id    = HALT;
        instr_valid = 1'b0;
        repeat (3) tick();
        check("t4_halted_e19", 64'(halted), 64'd0);
        check("t4_cycles_e19", 64'(cycles), 64'd19);
        check("t4_cpu_run_e19", 64'(cpu_run), 64'd1);
        instr_valid = 1'b1;
        tick();
        instr_id = NOP;
        check("t4_halted_e20", 64'(halted), 64'd1);
        check("t4_cycles_e20", 64'(cycles), 64'd20);
        repeat (2) tick();
        check("t4_cycles_e22", 64'(cycles), 64'd22);
        check("t4_cpu_run_e22", 64'(cpu_run), 64'd0);
        run_dump("t4", 1'b1, DEPTH, got);
        check("t4_words", 64'(got), 64'(DEPTH));
        check_done("t4", 22, 1'b1, 1'b0);

        // Reset in the middle of a dump, then a fresh run halting at edge 5.
        RESET_N = 1'b0;
        #1;
        release_reset();
        instr_valid = 1'b1;
        repeat (7) tick();
        instr_id = HALT;
        tick();
        instr_id = NOP;
        run_dump("t5a", 1'b1, 100, got);
        check("t5a_words", 64'(got), 64'd100);
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset("rst_mid");
        release_reset();
        repeat (4) tick();
        instr_id = HALT;
        tick();
        instr_id = NOP;
        check("t5_cycles_e5", 64'(cycles), 64'd5);
        repeat (2) tick();
        check("t5_cycles_e7", 64'(cycles), 64'd7);
        run_dump("t5", 1'b0, DEPTH, got);
        check("t5_words", 64'(got), 64'(DEPTH));
        check_done("t5", 7, 1'b1, 1'b0);

`ifdef RUN_MONITOR_TIMEOUT_EN
        // Watchdog at 50 cycles with no halt.
        RESET_N = 1'b0;
        #1;
        release_reset();
        repeat (49) tick();
        check("t6_to_e49", 64'(timed_out), 64'd0);
        tick();
        check("t6_to_e50", 64'(timed_out), 64'd1);
        check("t6_halted_e50", 64'(halted), 64'd0);
        check("t6_cycles_e50", 64'(cycles), 64'd50);
        repeat (2) tick();
        check("t6_cycles_e52", 64'(cycles), 64'd52);
        check("t6_cpu_run_e52", 64'(cpu_run), 64'd0);
        run_dump("t6", 1'b1, DEPTH, got);
        check("t6_words", 64'(got), 64'(DEPTH));
        check_done("t6", 52, 1'b0, 1'b1);

        // Halt and watchdog on the same edge: halt wins.
        RESET_N = 1'b0;
        #1;
        release_reset();
        repeat (49) tick();
        instr_id = HALT;
        tick();
        instr_id = NOP;
        check("t7_halted", 64'(halted), 64'd1);
        check("t7_timed_out", 64'(timed_out), 64'd0);
        check("t7_cycles", 64'(cycles), 64'd50);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
